// File: rtl/opcode_pipe_ctrl.sv
// Two-stage EX/WB opcode pipeline controller with a two-cycle MUL in EX.
// Define OPCODE_PIPE_PERF_EN to add the 16-bit retire_cnt output.
module opcode_pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [2:0]  in_opcode,
    output logic        in_ready,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [2:0]  ex_alu_sel,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        wb_valid,
    output logic        wb_reg_we,
    output logic [2:0]  wb_opcode,
    output logic        busy
`ifdef OPCODE_PIPE_PERF_EN
    ,
    output logic [15:0] retire_cnt
`endif
);

    localparam logic [1:0] EX_IDLE = 2'd0;
    localparam logic [1:0] EX_ONE  = 2'd1;
    localparam logic [1:0] EX_MUL1 = 2'd2;
    localparam logic [1:0] EX_MUL2 = 2'd3;

    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_LD  = 3'b110;
    localparam logic [2:0] OP_ST  = 3'b111;

    logic [1:0] state_q, state_d;
    logic [2:0] ex_op_q, ex_op_d;
    logic       wb_valid_q, wb_valid_d;
    logic [2:0] wb_op_q, wb_op_d;
    logic       accept;

    // rst_n is folded in so the port reads 0 for the whole reset window.
    assign in_ready = rst_n & ~stall & ~flush & (state_q != EX_MUL1);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        ex_op_d    = ex_op_q;
        wb_valid_d = wb_valid_q;
        wb_op_d    = wb_op_q;
        if (flush) begin
            state_d    = EX_IDLE;
            wb_valid_d = 1'b0;
        end else if (!stall) begin
            wb_valid_d = (state_q == EX_ONE) || (state_q == EX_MUL2);
            if (wb_valid_d) begin
                wb_op_d = ex_op_q;
            end
            if (accept) begin
                ex_op_d = in_opcode;
                state_d = (in_opcode == OP_MUL) ? EX_MUL1 : EX_ONE;
            end else if (state_q == EX_MUL1) begin
                state_d = EX_MUL2;
            end else begin
                state_d = EX_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EX_IDLE;
            ex_op_q    <= 3'b000;
            wb_valid_q <= 1'b0;
            wb_op_q    <= 3'b000;
        end else begin
            state_q    <= state_d;
            ex_op_q    <= ex_op_d;
            wb_valid_q <= wb_valid_d;
            wb_op_q    <= wb_op_d;
        end
    end

    // Decoded strobes are forced low whenever the stage is empty.
    assign ex_valid   = (state_q != EX_IDLE);
    assign ex_alu_sel = ex_valid ? ex_op_q : 3'b000;
    assign ex_mem_rd  = ex_valid && (ex_op_q == OP_LD);
    assign ex_mem_wr  = ex_valid && (ex_op_q == OP_ST);

    assign wb_valid   = wb_valid_q;
    assign wb_opcode  = wb_valid_q ? wb_op_q : 3'b000;
    assign wb_reg_we  = wb_valid_q && (wb_op_q != OP_ST);
    assign busy       = ex_valid | wb_valid_q;

`ifdef OPCODE_PIPE_PERF_EN
    logic [15:0] retire_cnt_q;

    // Not cleared by flush; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= 16'h0000;
        end else if (wb_valid_q && !stall) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_opcode_pipe_ctrl.sv
// Self-checking bench for opcode_pipe_ctrl: directed scenario tasks plus a
// retirement-order scoreboard. Covers retire_cnt when OPCODE_PIPE_PERF_EN is set.
module tb_opcode_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_opcode = 3'b000;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic        ex_valid;
    logic [2:0]  ex_alu_sel;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        wb_valid;
    logic        wb_reg_we;
    logic [2:0]  wb_opcode;
    logic        busy;
`ifdef OPCODE_PIPE_PERF_EN
    logic [15:0] retire_cnt;
`endif

    opcode_pipe_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_alu_sel (ex_alu_sel),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .wb_valid   (wb_valid),
        .wb_reg_we  (wb_reg_we),
        .wb_opcode  (wb_opcode),
        .busy       (busy)
`ifdef OPCODE_PIPE_PERF_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: accepted ops queue in order; mdl_mul1 blocks one cycle after a MUL.
    logic [2:0] exp_q[$];
    logic       mdl_mul1 = 1'b0;
    logic       adv;
    logic       exp_ready;
    logic [2:0] exp_op;

    always @(posedge clk) begin
        adv = 1'b0;
        if (!rst_n || flush) begin
            mdl_mul1 = 1'b0;
            exp_q.delete();
        end else if (!stall) begin
            adv = 1'b1;
            if (mdl_mul1) begin
                mdl_mul1 = 1'b0;
            end else if (in_valid) begin
                exp_q.push_back(in_opcode);
                mdl_mul1 = (in_opcode == 3'b101);
            end
        end
        #2;
        exp_ready = rst_n && !stall && !flush && !mdl_mul1;
        n_checks++;
        if (in_ready !== exp_ready)
            $display("FAIL sb_in_ready @%0t: got %b want %b", $time, in_ready, exp_ready);
        else
            n_pass++;
        if (adv && wb_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_wb @%0t: got op %b want none", $time, wb_opcode);
            end else begin
                exp_op = exp_q.pop_front();
                if ({wb_opcode, wb_reg_we} !== {exp_op, exp_op != 3'b111})
                    $display("FAIL sb_wb @%0t: got op/we %b/%b want %b/%b", $time,
                             wb_opcode, wb_reg_we, exp_op, exp_op != 3'b111);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_opcode = 3'b101;
        #12;
        n_checks++;
        if ({ex_valid, ex_alu_sel, ex_mem_rd, ex_mem_wr, wb_valid, wb_reg_we, wb_opcode, busy,
             in_ready} !== 14'b0)
            $display("FAIL reset_outputs: got %b want 0", {ex_valid, ex_alu_sel, ex_mem_rd,
                     ex_mem_wr, wb_valid, wb_reg_we, wb_opcode, busy, in_ready});
        else
            n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_seq();
        in_valid = 1'b1;
        in_opcode = 3'b000;
        @(negedge clk);
        n_checks++;
        if ({ex_valid, ex_alu_sel, wb_valid} !== 5'b1_000_0)
            $display("FAIL seq_ex0: got %b want 10000", {ex_valid, ex_alu_sel, wb_valid});
        else
            n_pass++;
        in_opcode = 3'b001;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_opcode, wb_reg_we, ex_alu_sel} !== 8'b1_000_1_001)
            $display("FAIL seq_wb0: got %b want 10001001", {wb_valid, wb_opcode, wb_reg_we,
                     ex_alu_sel});
        else
            n_pass++;
        in_opcode = 3'b010;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_opcode, wb_reg_we} !== 5'b1_001_1)
            $display("FAIL seq_wb1: got %b want 10011", {wb_valid, wb_opcode, wb_reg_we});
        else
            n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_opcode, wb_reg_we, ex_valid} !== 6'b1_010_1_0)
            $display("FAIL seq_wb2: got %b want 101010", {wb_valid, wb_opcode, wb_reg_we,
                     ex_valid});
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, busy} !== 2'b00)
            $display("FAIL seq_drain: got %b want 00", {wb_valid, busy});
        else
            n_pass++;
    endtask

    task automatic test_mul();
        in_valid = 1'b1;
        in_opcode = 3'b101;
        @(negedge clk);
        n_checks++;
        if ({in_ready, ex_valid, ex_alu_sel} !== 5'b0_1_101)
            $display("FAIL mul_block: got %b want 01101", {in_ready, ex_valid, ex_alu_sel});
        else
            n_pass++;
        in_opcode = 3'b000;
        @(negedge clk);
        n_checks++;
        if ({in_ready, wb_valid, ex_alu_sel} !== 5'b1_0_101)
            $display("FAIL mul_stage2: got %b want 10101", {in_ready, wb_valid, ex_alu_sel});
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_opcode, ex_alu_sel} !== 7'b1_101_000)
            $display("FAIL mul_wb: got %b want 1101000", {wb_valid, wb_opcode, ex_alu_sel});
        else
            n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_opcode} !== 4'b1_000)
            $display("FAIL mul_next_wb: got %b want 1000", {wb_valid, wb_opcode});
        else
            n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mem();
        in_valid = 1'b1;
        in_opcode = 3'b111;
        @(negedge clk);
        n_checks++;
        if ({ex_mem_wr, ex_mem_rd} !== 2'b10)
            $display("FAIL mem_st_ex: got wr/rd %b want 10", {ex_mem_wr, ex_mem_rd});
        else
            n_pass++;
        in_opcode = 3'b110;
        @(negedge clk);
        n_checks++;
        if ({ex_mem_wr, ex_mem_rd, wb_valid, wb_reg_we} !== 4'b0110)
            $display("FAIL mem_ld_ex: got %b want 0110", {ex_mem_wr, ex_mem_rd, wb_valid,
                     wb_reg_we});
        else
            n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ex_valid, ex_mem_rd, ex_mem_wr, ex_alu_sel, wb_reg_we} !== 7'b000_000_1)
            $display("FAIL mem_ld_wb: got %b want 0000001", {ex_valid, ex_mem_rd, ex_mem_wr,
                     ex_alu_sel, wb_reg_we});
        else
            n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stall_flush();
        in_valid = 1'b1;
        in_opcode = 3'b011;
        @(negedge clk);
        in_opcode = 3'b100;
        @(negedge clk);
        stall = 1'b1;
        in_opcode = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, ex_valid, ex_alu_sel, wb_valid, wb_opcode, wb_reg_we, busy}
                !== 11'b0_1_100_1_011_1_1)
                $display("FAIL stall_hold%0d: got %b want 01100101111", i, {in_ready, ex_valid,
                         ex_alu_sel, wb_valid, wb_opcode, wb_reg_we, busy});
            else
                n_pass++;
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0)
            $display("FAIL flush_ready: got %b want 0", in_ready);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ex_valid, wb_valid, busy} !== 3'b000)
            $display("FAIL flush_kill: got %b want 000", {ex_valid, wb_valid, busy});
        else
            n_pass++;
        flush = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        in_valid = 1'b1;
        in_opcode = 3'b101;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ex_valid, ex_alu_sel, wb_valid, busy, in_ready} !== 7'b0)
            $display("FAIL rst_async: got %b want 0", {ex_valid, ex_alu_sel, wb_valid, busy,
                     in_ready});
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_opcode = 3'b010;
        @(negedge clk);
        n_checks++;
        if ({ex_valid, ex_alu_sel, wb_valid} !== 5'b1_010_0)
            $display("FAIL rst_first_accept: got %b want 10100", {ex_valid, ex_alu_sel,
                     wb_valid});
        else
            n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_opcode} !== 4'b1_010)
            $display("FAIL rst_no_mul_wb: got %b want 1010", {wb_valid, wb_opcode});
        else
            n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_opcode = 3'($urandom_range(0, 7));
            stall = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n_checks++;
            if (busy !== (ex_valid | wb_valid))
                $display("FAIL b2b_busy: got %b want %b", busy, ex_valid | wb_valid);
            else
                n_pass++;
        end
        in_valid = 1'b0;
        stall = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL b2b_drain: got %0d pending, busy %b want 0, 0", exp_q.size(), busy);
        else
            n_pass++;
    endtask

`ifdef OPCODE_PIPE_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (retire_cnt !== 16'h0000)
            $display("FAIL perf_reset: got %h want 0000", retire_cnt);
        else
            n_pass++;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_opcode = 3'b000;
        repeat (65537) @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wb_valid, retire_cnt} !== {1'b0, 16'h0001})
            $display("FAIL perf_wrap: got %b/%h want 0/0001", wb_valid, retire_cnt);
        else
            n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_seq();
        test_mul();
        test_mem();
        test_stall_flush();
        test_reset_mid_mul();
        test_back_to_back();
`ifdef OPCODE_PIPE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
